// File: rtl/conv3d_mac_ctrl.sv
// conv3d_mac_ctrl: sequences a 3-lane MAC over a valid 3x3xCH convolution.
// For each output pixel it clears the MAC and streams 3*CH kernel-row reads,
// then presents the result through a valid/ready handshake. All outputs are registered.
module conv3d_mac_ctrl #(
  parameter int unsigned IMG_W  = 8,
  parameter int unsigned IMG_H  = 8,
  parameter int unsigned CH     = 4,
  parameter int unsigned ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] act_addr,
  output logic [ADDR_W-1:0] wgt_addr,
  output logic              mac_rst,
  output logic              mac_load,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [15:0]       out_x,
  output logic [15:0]       out_y,
  output logic              busy,
  output logic              done
);

  localparam int unsigned OutW   = IMG_W - 2;
  localparam int unsigned OutH   = IMG_H - 2;
  localparam int unsigned NSteps = 3 * CH;

  localparam logic [15:0] LastX    = 16'(OutW - 1);
  localparam logic [15:0] LastY    = 16'(OutH - 1);
  localparam logic [15:0] LastC    = 16'(CH - 1);
  localparam logic [15:0] LastStep = 16'(NSteps - 1);

  typedef enum logic [2:0] {StIdle, StClear, StAccum, StOut, StDone} state_e;

  state_e state_q, state_d;

  logic [15:0] ox_q, ox_d;
  logic [15:0] oy_q, oy_d;
  logic [15:0] cnt_q, cnt_d;  // ACCUM cycle index
  logic [15:0] c_q, c_d;      // channel of the step currently on the address bus
  logic [1:0]  kr_q, kr_d;    // kernel row of the step currently on the address bus
  logic        issue;
  logic        last_issued;

  logic [ADDR_W-1:0] act_calc, wgt_calc;
  logic [ADDR_W-1:0] act_addr_d, wgt_addr_d;
  logic              mac_rst_d, mac_load_d, out_valid_d, busy_d, done_d;
  logic [15:0]       out_x_d, out_y_d;

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      ox_q    <= '0;
      oy_q    <= '0;
      cnt_q   <= '0;
      c_q     <= '0;
      kr_q    <= '0;
    end else begin
      state_q <= state_d;
      ox_q    <= ox_d;
      oy_q    <= oy_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
      kr_q    <= kr_d;
    end
  end

  // Next-state, step sequencing and next values of the registered outputs.
  always_comb begin
    state_d = state_q;
    ox_d    = ox_q;
    oy_d    = oy_q;
    cnt_d   = cnt_q;
    c_d     = c_q;
    kr_d    = kr_q;
    issue   = 1'b0;

    last_issued = (kr_q == 2'd2) && (c_q == LastC);

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StClear;
          ox_d    = '0;
          oy_d    = '0;
          c_d     = '0;
          kr_d    = '0;
          issue   = 1'b1;
        end
      end
      StClear: begin
        state_d = StAccum;
        cnt_d   = '0;
      end
      StAccum: begin
        cnt_d = cnt_q + 16'd1;
        if (cnt_q == LastStep) begin
          state_d = StOut;
        end
      end
      StOut: begin
        if (out_ready) begin
          if ((ox_q == LastX) && (oy_q == LastY)) begin
            state_d = StDone;
          end else begin
            state_d = StClear;
            if (ox_q == LastX) begin
              ox_d = '0;
              oy_d = oy_q + 16'd1;
            end else begin
              ox_d = ox_q + 16'd1;
            end
            c_d   = '0;
            kr_d  = '0;
            issue = 1'b1;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // The bus shows step i+1 during ACCUM cycle i, so advance from CLEAR onward
    // until the final step is on the bus, then hold it.
    if (((state_q == StClear) || (state_q == StAccum)) && !last_issued) begin
      issue = 1'b1;
      if (kr_q == 2'd2) begin
        kr_d = '0;
        c_d  = c_q + 16'd1;
      end else begin
        kr_d = kr_q + 2'd1;
      end
    end

    act_calc = ADDR_W'((32'(c_d) * IMG_H + 32'(oy_d) + 32'(kr_d)) * IMG_W + 32'(ox_d));
    wgt_calc = ADDR_W'(32'(c_d) * 32'd3 + 32'(kr_d));

    act_addr_d  = issue ? act_calc : act_addr;
    wgt_addr_d  = issue ? wgt_calc : wgt_addr;
    if (state_d == StIdle) begin
      act_addr_d = '0;
      wgt_addr_d = '0;
    end
    mac_rst_d   = (state_d == StClear);
    mac_load_d  = (state_d == StAccum);
    out_valid_d = (state_d == StOut);
    out_x_d     = (state_d == StOut) ? ox_d : 16'd0;
    out_y_d     = (state_d == StOut) ? oy_d : 16'd0;
    busy_d      = (state_d != StIdle);
    done_d      = (state_d == StDone);
  end

  // Output registers; nothing reaches an output combinationally.
  always_ff @(posedge clk) begin
    if (rst) begin
      act_addr  <= '0;
      wgt_addr  <= '0;
      mac_rst   <= 1'b0;
      mac_load  <= 1'b0;
      out_valid <= 1'b0;
      out_x     <= '0;
      out_y     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      act_addr  <= act_addr_d;
      wgt_addr  <= wgt_addr_d;
      mac_rst   <= mac_rst_d;
      mac_load  <= mac_load_d;
      out_valid <= out_valid_d;
      out_x     <= out_x_d;
      out_y     <= out_y_d;
      busy      <= busy_d;
      done      <= done_d;
    end
  end

endmodule

// File: tb/tb_conv3d_mac_ctrl.sv
// tb_conv3d_mac_ctrl: directed bench for conv3d_mac_ctrl on a 4x4x2 layer (N = 6).
// Expected addresses and pixels are queued when a pass is started and popped
// at the cycles the timeline says they must appear.
module tb_conv3d_mac_ctrl;

  localparam int unsigned IMG_W  = 4;
  localparam int unsigned IMG_H  = 4;
  localparam int unsigned CH     = 2;
  localparam int unsigned ADDR_W = 16;
  localparam int N     = 3 * CH;
  localparam int OUT_W = IMG_W - 2;
  localparam int OUT_H = IMG_H - 2;
  localparam int NPIX  = OUT_W * OUT_H;
  localparam int ACT_V = 2;
  localparam int WGT_V = -3;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              out_ready;
  logic [ADDR_W-1:0] act_addr;
  logic [ADDR_W-1:0] wgt_addr;
  logic              mac_rst;
  logic              mac_load;
  logic              out_valid;
  logic [15:0]       out_x;
  logic [15:0]       out_y;
  logic              busy;
  logic              done;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct { int act; int wgt; } addr_t;
  typedef struct { int x; int y; int acc; } pix_t;
  addr_t addr_q[$];
  pix_t  pix_q[$];

  // Buffer and MAC model: constant data, one-cycle read latency.
  int act_rd, wgt_rd, acc;

  always #5 clk = ~clk;

  conv3d_mac_ctrl #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .CH    (CH),
    .ADDR_W(ADDR_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .act_addr (act_addr),
    .wgt_addr (wgt_addr),
    .mac_rst  (mac_rst),
    .mac_load (mac_load),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_x    (out_x),
    .out_y    (out_y),
    .busy     (busy),
    .done     (done)
  );

  // Three-lane MAC fed by the buffer model.
  always @(posedge clk) begin
    act_rd <= ACT_V;
    wgt_rd <= WGT_V;
    if (rst || mac_rst) acc <= 0;
    else if (mac_load) acc <= acc + 3 * act_rd * wgt_rd;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string pfx);
    chk({pfx, "_act_addr"}, 32'(act_addr), 0);
    chk({pfx, "_wgt_addr"}, 32'(wgt_addr), 0);
    chk({pfx, "_mac_rst"}, 32'(mac_rst), 0);
    chk({pfx, "_mac_load"}, 32'(mac_load), 0);
    chk({pfx, "_out_valid"}, 32'(out_valid), 0);
    chk({pfx, "_out_x"}, 32'(out_x), 0);
    chk({pfx, "_out_y"}, 32'(out_y), 0);
    chk({pfx, "_busy"}, 32'(busy), 0);
    chk({pfx, "_done"}, 32'(done), 0);
  endtask

  // One full layer pass; bp = cycles of out_ready=0 at the first OUT.
  task automatic run_pass(input int bp, input bit poke_start);
    int clr[NPIX];
    int outc[NPIX];
    int done_c;
    int hold_act, hold_wgt, hold_x, hold_y;
    bit e_rst, e_load, e_valid, e_issue, e_first;
    addr_t a;
    pix_t  px;

    for (int p = 0; p < NPIX; p++) begin
      clr[p]  = 1 + p * (N + 2) + ((p > 0) ? bp : 0);
      outc[p] = clr[p] + N + 1;
    end
    done_c = outc[NPIX-1] + 1;

    for (int p = 0; p < NPIX; p++) begin
      int x, y;
      x = p % OUT_W;
      y = p / OUT_W;
      for (int c = 0; c < CH; c++) begin
        for (int kr = 0; kr < 3; kr++) begin
          a.act = (c * IMG_H + y + kr) * IMG_W + x;
          a.wgt = c * 3 + kr;
          addr_q.push_back(a);
        end
      end
      px.x   = x;
      px.y   = y;
      px.acc = N * 3 * (ACT_V * WGT_V);
      pix_q.push_back(px);
    end

    hold_act = 0;
    hold_wgt = 0;
    hold_x   = 0;
    hold_y   = 0;
    out_ready = 1'b1;
    start     = 1'b1;
    tick();
    start = 1'b0;

    for (int cyc = 1; cyc <= done_c + 1; cyc++) begin
      e_rst = 0; e_load = 0; e_valid = 0; e_issue = 0; e_first = 0;
      for (int p = 0; p < NPIX; p++) begin
        if (cyc == clr[p]) e_rst = 1;
        if (cyc > clr[p] && cyc <= clr[p] + N) e_load = 1;
        if (cyc >= clr[p] && cyc < clr[p] + N) e_issue = 1;
        if (cyc >= outc[p] && cyc <= outc[p] + ((p == 0) ? bp : 0)) e_valid = 1;
        if (cyc == outc[p]) e_first = 1;
      end

      chk("busy", 32'(busy), 32'(cyc <= done_c));
      chk("done", 32'(done), 32'(cyc == done_c));
      chk("mac_rst", 32'(mac_rst), 32'(e_rst));
      chk("mac_load", 32'(mac_load), 32'(e_load));
      chk("out_valid", 32'(out_valid), 32'(e_valid));

      if (e_issue && addr_q.size() > 0) begin
        a = addr_q.pop_front();
        hold_act = a.act;
        hold_wgt = a.wgt;
      end
      if (cyc < done_c) begin
        chk("act_addr", 32'(act_addr), hold_act);
        chk("wgt_addr", 32'(wgt_addr), hold_wgt);
      end else if (cyc > done_c) begin
        chk_all_zero("idle_after_done");
      end

      if (e_first && pix_q.size() > 0) begin
        px = pix_q.pop_front();
        hold_x = px.x;
        hold_y = px.y;
        chk("mac_acc", acc, px.acc);
      end
      if (e_valid) begin
        chk("out_x", 32'(out_x), hold_x);
        chk("out_y", 32'(out_y), hold_y);
        chk("mac_acc_stable", acc, N * 3 * (ACT_V * WGT_V));
      end

      out_ready = !(bp > 0 && cyc >= outc[0] && cyc < outc[0] + bp);
      start     = poke_start && (cyc == 4 || cyc == 10 || cyc == done_c);
      tick();
    end
    start     = 1'b0;
    out_ready = 1'b1;
    chk("addr_q_empty", addr_q.size(), 0);
    chk("pix_q_empty", pix_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst       = 1'b1;
    start     = 1'b1;
    out_ready = 1'b0;
    tick();
    chk_all_zero("reset1");
    tick();
    chk_all_zero("reset2");
    rst   = 1'b0;
    start = 1'b0;
    tick();
    chk_all_zero("after_reset");

    // Plain pass: OUT at 8,16,24,32; done at 33.
    run_pass(0, 1'b0);

    // Reset in the middle of ACCUM.
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    chk("midrst_in_accum", 32'(mac_load), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_all_zero("midrst");
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("midrst_no_done", 32'(done), 0);
      chk("midrst_idle", 32'(busy), 0);
    end

    // Backpressure of 5 cycles at the first OUT, with stray start pulses.
    run_pass(5, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/conv3d_mac_ctrl.md
# conv3d_mac_ctrl

Sequencer for the 3-lane 8-bit MAC datapath used in 3D convolution. For each output pixel of a valid (no-padding) 3x3xCH convolution it clears the MAC, then streams 3*CH kernel-row reads from the activation and weight buffers into the MAC. It presents the finished accumulation to a downstream consumer through a valid/ready handshake. It sits between the start/done control of the convolution layer, the two read-only buffers, and the MAC's `rst`/`load` inputs.

## Interface
Parameters:
- `IMG_W`, default 8: input feature-map width in pixels; must be >= 3.
- `IMG_H`, default 8: input feature-map height in pixels; must be >= 3.
- `CH`, default 4: number of input channels; must be >= 1.
- `ADDR_W`, default 16: width of both buffer address buses.

Ports:
- `clk` in 1: single clock; all logic is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: begin one full layer pass; sampled only in IDLE.
- `act_addr` out ADDR_W: activation buffer row address. The buffer returns 3 consecutive pixels one cycle later.
- `wgt_addr` out ADDR_W: weight buffer address. The buffer returns 3 weights (one kernel row) one cycle later.
- `mac_rst` out 1: drives the MAC's synchronous clear.
- `mac_load` out 1: drives the MAC's accumulate enable.
- `out_valid` out 1: MAC output holds a finished pixel.
- `out_ready` in 1: consumer accepts the pixel.
- `out_x` out 16: x coordinate of the presented pixel.
- `out_y` out 16: y coordinate of the presented pixel.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse after the last pixel is accepted.

## Operation
- Output grid is OUT_W = IMG_W-2 by OUT_H = IMG_H-2, visited in raster order with ox fastest.
- Per pixel, N = 3*CH steps are issued. Step order is kr (0..2) fastest, then c (0..CH-1).
- Address formulas:
  - act_addr = (c*IMG_H + oy + kr)*IMG_W + ox
  - wgt_addr = c*3 + kr
  - Both are truncated to ADDR_W.
- State machine: IDLE, CLEAR, ACCUM, OUT, DONE.
  - IDLE: all outputs 0.
    - start=1 -> CLEAR, with ox=oy=0.
  - CLEAR (1 cycle):
    - mac_rst=1.
    - Issue step 0 addresses.
    - -> ACCUM.
  - ACCUM (exactly N cycles):
    - In ACCUM cycle i, issue addresses for step i+1 while i+1 < N.
    - After the last issue, addresses hold their last value.
    - mac_load=1 in every ACCUM cycle.
    - mac_load is the address-issue strobe delayed one cycle, so it aligns with buffer read data.
    - After the N-th cycle -> OUT.
  - OUT:
    - out_valid=1; out_x/out_y = current ox/oy.
    - mac_load=0 and mac_rst=0, so the MAC output is stable.
    - Holds while out_ready=0.
    - On out_ready=1 with the pixel not last: advance ox (wrap to 0 and increment oy at OUT_W-1) -> CLEAR.
    - On out_ready=1 with the last pixel (ox=OUT_W-1, oy=OUT_H-1) -> DONE.
  - DONE (1 cycle): done=1 -> IDLE.
- `start` is ignored in every state except IDLE.
- `rst` in any state:
  - Next state is IDLE; all counters and outputs are 0.
  - In-flight accumulation is discarded without a done pulse.
- out_ready is ignored outside OUT.

## Timing
- Reset value of every output is 0: act_addr, wgt_addr, mac_rst, mac_load, out_valid, out_x, out_y, busy, done.
- All outputs are registered; no combinational path from out_ready or start to any output.
- Layer pass, with start sampled at cycle 0:
  - CLEAR at cycle 1.
  - ACCUM at cycles 2..N+1.
  - First OUT at cycle N+2.
- Per-pixel period with out_ready held high is N+2 cycles.
- Each cycle out_ready=0 in OUT adds one cycle.
- done is asserted exactly one cycle after the final accepted OUT cycle.
- The MAC clears at the edge ending CLEAR, so ACCUM cycle 0's load adds to 0.

## Test plan
- Reset values:
  - Stimulus: assert rst for 2 cycles with start=1.
  - Required: all outputs 0; state IDLE after release (busy=0).
- Address sequence, IMG_W=4, IMG_H=4, CH=2 (N=6):
  - Pixel (0,0): act_addr 0,4,8,16,20,24 and wgt_addr 0..5, one per cycle starting at CLEAR.
  - mac_load high for the 6 cycles after CLEAR.
  - Pixel (1,0): act_addr 1,5,9,17,21,25.
- Full pass, same config, out_ready=1:
  - out_valid at cycles 8, 16, 24, 32 with (x,y) = (0,0), (1,0), (0,1), (1,1).
  - done at cycle 33; busy low from cycle 34.
- Backpressure:
  - Stimulus: out_ready=0 for 5 cycles at the first OUT.
  - Required: out_valid held, out_x/out_y stable, mac_load=0, no new address issue; second pixel's OUT and done each shift by 5 cycles.
- End-to-end with a MAC model:
  - Stimulus: all activations=2, all weights=-3, CH=2.
  - Required: each pixel's MAC output = 6 steps * 3 lanes * (-6) = -108.
- Reset mid-operation and start while busy:
  - rst during ACCUM: IDLE next cycle, no done pulse.
  - start pulsed during ACCUM/OUT: no effect on sequence or counters.
